// File: rtl/ahb3lite_to_wb_bridge.sv
// ---------------------------------------------------------------------------
// ahb3lite_to_wb_bridge
//   AHB3-Lite slave to Wishbone (classic, single-cycle) master bridge.
//   Every accepted AHB beat becomes one Wishbone single cycle; HBURST and
//   HPROT are ignored. With a zero-wait Wishbone slave the AHB data phase
//   takes 2 cycles. Each extra Wishbone wait cycle adds one cycle.
//
//   Optional feature macro: AHB2WB_ERR_EN
//     defined   : wb_err_i produces a two-cycle AHB ERROR response
//                 (states ERR1/ERR2). err beats ack, and ack beats rty.
//     undefined : wb_err_i is treated as wb_ack_i and HRESP is always 0.
//
// Ports
//   clk_i, rst_i        : clock (rising edge), async active-high reset
//   HSEL..HREADY        : AHB3-Lite slave inputs
//   HRDATA, HREADYOUT,
//   HRESP               : AHB3-Lite slave outputs
//   wb_adr_o..wb_stb_o  : Wishbone master outputs
//   wb_dat_i, wb_ack_i,
//   wb_err_i, wb_rty_i  : Wishbone master inputs
// ---------------------------------------------------------------------------
module ahb3lite_to_wb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i
);

`ifdef AHB2WB_ERR_EN
  typedef enum logic [2:0] {ST_IDLE, ST_ACCESS, ST_RETRY, ST_RESP, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_ACCESS, ST_RETRY, ST_RESP} state_t;
`endif

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [3:0]            r_sel;
  logic                  r_we;
  logic                  r_cyc;
  logic                  r_stb;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic                  r_hreadyout;
  logic                  r_hresp;

  logic                  w_accept;
  logic                  w_ack;
  logic                  w_unused;

  // Little-endian byte lanes for the transfer size; anything word or wider uses all lanes.
  function automatic logic [3:0] sel_from_size(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    sel_from_size = 4'b0001 << a;
      3'd1:    sel_from_size = a[1] ? 4'b1100 : 4'b0011;
      default: sel_from_size = 4'b1111;
    endcase
  endfunction

  // Only NONSEQ/SEQ start a transfer; IDLE and BUSY fall through with the
  // zero-wait OKAY that IDLE/RESP already present.
  assign w_accept = HSEL & HREADY & HTRANS[1];

`ifdef AHB2WB_ERR_EN
  assign w_ack = wb_ack_i;
`else
  assign w_ack = wb_ack_i | wb_err_i;
`endif

  assign w_unused  = ^{HBURST, HPROT, HTRANS[0]};

  // Write data passes straight through: AHB keeps HWDATA stable while HREADYOUT is low.
  assign wb_dat_o  = HWDATA;
  assign wb_adr_o  = r_adr;
  assign wb_sel_o  = r_sel;
  assign wb_we_o   = r_we;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign HRDATA    = r_hrdata;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

  // Bridge FSM with registered AHB and Wishbone outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_adr       <= '0;
      r_sel       <= 4'b0000;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_hrdata    <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
`ifdef AHB2WB_ERR_EN
        ST_IDLE, ST_RESP, ST_ERR2: begin
`else
        ST_IDLE, ST_RESP: begin
`endif
          if (w_accept) begin
            r_adr       <= HADDR;
            r_we        <= HWRITE;
            r_sel       <= sel_from_size(HSIZE, HADDR[1:0]);
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b0;
            r_state     <= ST_ACCESS;
          end else begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
`ifdef AHB2WB_ERR_EN
          if (wb_err_i) begin
            // First ERROR cycle: HRESP high while HREADYOUT is still low.
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
            r_state     <= ST_ERR1;
          end else
`endif
          if (w_ack) begin
            if (!r_we) begin
              r_hrdata <= wb_dat_i;
            end
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_state     <= ST_RESP;
          end else if (wb_rty_i) begin
            // Drop the strobe for one cycle, then re-issue the same beat.
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b0;
            r_state     <= ST_RETRY;
          end else begin
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b0;
            r_state     <= ST_ACCESS;
          end
        end
        ST_RETRY: begin
          r_cyc       <= 1'b1;
          r_stb       <= 1'b1;
          r_hreadyout <= 1'b0;
          r_hresp     <= 1'b0;
          r_state     <= ST_ACCESS;
        end
`ifdef AHB2WB_ERR_EN
        ST_ERR1: begin
          r_cyc       <= 1'b0;
          r_stb       <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
          r_state     <= ST_ERR2;
        end
`endif
        default: begin
          r_cyc       <= 1'b0;
          r_stb       <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_to_wb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_to_wb_bridge
//   Randomized AHB master + Wishbone slave around ahb3lite_to_wb_bridge.
//   The driver pushes expected Wishbone requests and expected AHB responses
//   into queues when a transfer is accepted; a Wishbone slave/monitor and an
//   AHB monitor pop and compare independently. Compile with AHB2WB_ERR_EN
//   defined to exercise the error-response build.
// ---------------------------------------------------------------------------
module tb_ahb3lite_to_wb_bridge;

  localparam int NTX    = 300;
  localparam int BUDGET = 20000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  always #5 clk_i = ~clk_i;

  ahb3lite_to_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  size;
    logic        we;
    logic [31:0] wdata;
    int          waits;
    int          rty;
    bit          err;
    bit          dual;
    logic [31:0] rdata;
  } tx_t;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    int          waits;
    int          rty;
    bit          err;
    bit          dual;
    logic [31:0] rdata;
  } wb_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    int          lat;
  } ahb_exp_t;

  wb_exp_t  wb_q[$];
  ahb_exp_t ahb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit run_en   = 1'b0;
  bit force_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected DUT activity, expected none", name);
  endtask

  // Transfer generator: the first few indexes are the directed scenarios.
  function automatic tx_t gen_tx(input int idx);
    tx_t t;
    t.adr   = $urandom;
    t.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    t.we    = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    t.waits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    t.rty   = ($urandom_range(0, 7) == 0) ? 1 : 0;
    t.err   = ($urandom_range(0, 9) == 0);
    t.dual  = ($urandom_range(0, 7) == 0);
    t.rdata = $urandom;
    case (idx)
      0: begin t.adr = 32'h100; t.size = 3'd2; t.we = 1'b1; t.wdata = 32'hDEADBEEF;
               t.waits = 0; t.rty = 0; t.err = 1'b0; t.dual = 1'b0; end
      1: begin t.adr = 32'h103; t.size = 3'd0; t.we = 1'b0; t.rdata = 32'h11223344;
               t.waits = 2; t.rty = 0; t.err = 1'b0; t.dual = 1'b0; end
      2: begin t.adr = 32'h0; t.size = 3'd2; t.we = 1'b1;
               t.waits = 0; t.rty = 0; t.err = 1'b0; t.dual = 1'b0; end
      3: begin t.adr = 32'h4; t.size = 3'd2; t.we = 1'b0;
               t.waits = 0; t.rty = 0; t.err = 1'b0; t.dual = 1'b0; end
      4: begin t.adr = 32'h80; t.size = 3'd2; t.we = 1'b1;
               t.waits = 0; t.rty = 1; t.err = 1'b0; t.dual = 1'b0; end
      5: begin t.adr = 32'h200; t.size = 3'd2; t.we = 1'b1;
               t.waits = 0; t.rty = 0; t.err = 1'b1; t.dual = 1'b0; end
      6: begin t.adr = 32'h302; t.size = 3'd1; t.we = 1'b0;
               t.waits = 1; t.rty = 0; t.err = 1'b0; t.dual = 1'b1; end
      default: ;
    endcase
    return t;
  endfunction

  // Wishbone slave model and request monitor.
  int s_cnt = 0;
  bit s_gap = 1'b0;
  always @(negedge clk_i) begin
    wb_ack_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = $urandom;
    if (!run_en) begin
      wb_ack_i = force_ack;
    end else if (s_gap) begin
      s_gap = 1'b0;
      check("retry_gap", {29'd0, wb_cyc_o, wb_stb_o, HREADYOUT}, 32'd0);
    end else if (wb_cyc_o && wb_stb_o) begin
      if (wb_q.size() == 0) begin
        fail("wb_unexpected_cycle");
      end else begin
        wb_exp_t e;
        e = wb_q[0];
        check("wb_adr", wb_adr_o, e.adr);
        check("wb_sel", {28'd0, wb_sel_o}, {28'd0, e.sel});
        check("wb_we", {31'd0, wb_we_o}, {31'd0, e.we});
        if (e.we) check("wb_dat", wb_dat_o, e.wdata);
        check("hreadyout_in_access", {31'd0, HREADYOUT}, 32'd0);
        if (s_cnt < e.waits) begin
          s_cnt++;
        end else begin
          s_cnt = 0;
          if (e.rty > 0) begin
            wb_rty_i = 1'b1;
            e.rty    = e.rty - 1;
            wb_q[0]  = e;
            s_gap    = 1'b1;
          end else begin
            wb_dat_i = e.rdata;
            if (e.err) begin
              wb_err_i = 1'b1;
              wb_ack_i = e.dual;
            end else begin
              wb_ack_i = 1'b1;
              wb_rty_i = e.dual;
            end
            void'(wb_q.pop_front());
          end
        end
      end
    end
  end

  // AHB response monitor: tracks data phases from the bus and checks completion.
  bit dp_active = 1'b0;
  int dp_cnt    = 0;
  always @(negedge clk_i) begin
    if (run_en) begin
      if (dp_active) begin
        dp_cnt++;
        if (ahb_q.size() == 0) begin
          fail("ahb_unexpected_data_phase");
          dp_active = 1'b0;
        end else if (HREADYOUT) begin
          ahb_exp_t e;
          e = ahb_q.pop_front();
          check("hrdata", HRDATA, e.rdata);
          check("hresp_final", {31'd0, HRESP}, {31'd0, e.resp});
          check("latency", dp_cnt, e.lat);
          dp_active = 1'b0;
        end else begin
          // Only the cycle before the final ERROR cycle shows HRESP with HREADYOUT low.
          check("hresp_wait", {31'd0, HRESP},
                {31'd0, (ahb_q[0].resp && dp_cnt == ahb_q[0].lat - 1)});
        end
      end else begin
        check("idle_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("idle_hresp", {31'd0, HRESP}, 32'd0);
      end
      if (HSEL && HREADY && HTRANS[1]) begin
        dp_active = 1'b1;
        dp_cnt    = 0;
      end
    end
  end

  tx_t         cur;
  bit          cur_valid;
  int          issued;
  int          cycles;
  logic [31:0] last_rd;

  initial begin
    rst_i = 1'b1; HSEL = 1'b0; HADDR = 32'd0; HWDATA = 32'd0; HWRITE = 1'b0;
    HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0; HTRANS = 2'b00; HREADY = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst_hresp", {31'd0, HRESP}, 32'd0);
    check("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("rst_we", {31'd0, wb_we_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    rst_i = 1'b0;

    // Reset in the middle of an ACCESS, then a late ack.
    @(posedge clk_i); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge clk_i); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h12345678; HREADY = HREADYOUT;
    @(negedge clk_i);
    check("pre_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);
    check("pre_rst_adr", wb_adr_o, 32'h40);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    check("midrst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("midrst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("midrst_adr", wb_adr_o, 32'd0);
    force_ack = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; HREADY = 1'b1;
    @(posedge clk_i); #1;
    force_ack = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("late_ack_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("late_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);
      check("late_ack_hrdata", HRDATA, 32'd0);
    end

    // Randomized traffic.
    @(posedge clk_i); #1;
    run_en    = 1'b1;
    cur_valid = 1'b0;
    issued    = 0;
    cycles    = 0;
    last_rd   = 32'd0;
    while ((issued < NTX || ahb_q.size() != 0) && cycles < BUDGET) begin
      @(posedge clk_i); #1;
      cycles++;
      if (HREADY && cur_valid) begin
        // Accepted at this edge: enter data phase and record expectations.
        wb_exp_t  w;
        ahb_exp_t a;
        bit       is_err;
        int       lane;
`ifdef AHB2WB_ERR_EN
        is_err = cur.err;
`else
        is_err = 1'b0;
`endif
        HWDATA = cur.wdata;
        lane   = int'(cur.adr % 4);
        w.adr  = cur.adr;
        w.sel  = (cur.size == 3'd0) ? 4'(1 << lane) :
                 (cur.size == 3'd1) ? ((lane >= 2) ? 4'd12 : 4'd3) : 4'd15;
        w.we   = cur.we;   w.wdata = cur.wdata; w.waits = cur.waits;
        w.rty  = cur.rty;  w.err   = cur.err;   w.dual  = cur.dual;
        w.rdata = cur.rdata;
        if (!cur.we && !is_err) last_rd = cur.rdata;
        a.rdata = last_rd;
        a.resp  = is_err;
        a.lat   = (cur.waits + 1) * (cur.rty + 1) + cur.rty + (is_err ? 2 : 1);
        wb_q.push_back(w);
        ahb_q.push_back(a);
        issued++;
        cur_valid = 1'b0;
      end
      HREADY = HREADYOUT;
      if (HREADY && !cur_valid) begin
        HBURST = 3'($urandom_range(0, 7));
        HPROT  = 4'($urandom_range(0, 15));
        if (issued >= NTX) begin
          HSEL = 1'b0; HTRANS = 2'b00;
        end else if (issued >= 7 && $urandom_range(0, 3) == 0) begin
          HSEL   = 1'($urandom_range(0, 1));
          HTRANS = HSEL ? 2'($urandom_range(0, 1)) : 2'b10;
          HADDR  = $urandom;
          HWRITE = 1'($urandom_range(0, 1));
        end else begin
          cur       = gen_tx(issued);
          cur_valid = 1'b1;
          HSEL   = 1'b1;
          HTRANS = 2'($urandom_range(2, 3));
          HADDR  = cur.adr;
          HWRITE = cur.we;
          HSIZE  = cur.size;
        end
      end
    end
    @(negedge clk_i);
    check("issued_all", issued, NTX);
    check("drain_ahb", ahb_q.size(), 0);
    check("drain_wb", wb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb3lite_to_wb_bridge.md
AHB3LITE_TO_WB_BRIDGE -- requirements
Module: ahb3lite_to_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the AHB and Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width (only 32 is supported).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_i, input, 1, the asynchronous active-high reset.
REQ-006 SHALL have AHB3-Lite slave inputs: HSEL 1, HADDR ADDR_WIDTH, HWDATA 32, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HTRANS 2, HREADY 1.
REQ-007 SHALL have AHB3-Lite slave outputs: HRDATA 32, HREADYOUT 1, HRESP 1.
REQ-008 SHALL have Wishbone master outputs: wb_adr_o ADDR_WIDTH, wb_dat_o 32, wb_sel_o 4, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1.
REQ-009 SHALL have Wishbone master inputs: wb_dat_i 32, wb_ack_i 1, wb_err_i 1, wb_rty_i 1.

Function
REQ-010 SHALL accept a transfer when HSEL & HREADY & HTRANS[1] are all 1 at a rising edge; HTRANS IDLE or BUSY gets a zero-wait OKAY response.
REQ-011 SHALL ignore HBURST and HPROT; each beat is a separate Wishbone single cycle.
REQ-012 SHALL implement the states IDLE, ACCESS, RETRY, RESP, ERR1 and ERR2.
REQ-013 On accept, SHALL register HADDR into wb_adr_o and HWRITE into wb_we_o, SHALL register wb_sel_o from HSIZE/HADDR[1:0], and SHALL go to ACCESS.
REQ-014 wb_sel_o encoding, little-endian: byte = 4'b0001 << HADDR[1:0]; halfword = HADDR[1] ? 4'b1100 : 4'b0011; word or larger = 4'b1111.
REQ-015 In ACCESS: wb_cyc_o=1, wb_stb_o=1, HREADYOUT=0, and wb_dat_o = HWDATA (combinational, stable by AHB wait-state rules).
REQ-016 ACCESS with wb_ack_i: on a read, SHALL register wb_dat_i into HRDATA; SHALL go to RESP and drop cyc/stb on the next cycle.
REQ-017 ACCESS with wb_rty_i and no ack: SHALL go to RETRY (cyc/stb=0, HREADYOUT=0 for one cycle), then back to ACCESS with the same address, data and sel.
REQ-018 In RESP: HREADYOUT=1 and HRESP=0; on a new accept SHALL go to ACCESS, otherwise to IDLE.
REQ-019 HRDATA SHALL hold its value except on a read acknowledge.
REQ-020 Minimum latency with a zero-wait Wishbone slave: the data phase is 2 cycles (one wait state); each extra Wishbone wait cycle adds one cycle.
REQ-021 Simultaneous responses: ack has priority over rty; err has priority over ack and rty when AHB2WB_ERR_EN is defined.
REQ-022 In IDLE: HREADYOUT=1, HRESP=0, cyc/stb=0.

Reset
REQ-023 While rst_i=1, SHALL immediately force state=IDLE, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_sel_o=0, HRDATA=0, HREADYOUT=1, HRESP=0.
REQ-024 Reset during ACCESS SHALL abort the Wishbone cycle without waiting for ack; a late ack after reset SHALL be ignored.

Configuration
REQ-025 Macro AHB2WB_ERR_EN, when defined: wb_err_i in ACCESS SHALL go to ERR1, then ERR2.
REQ-026 ERR1: HRESP=1, HREADYOUT=0, cyc/stb=0. ERR2: HRESP=1, HREADYOUT=1. From ERR2, an accept goes to ACCESS; otherwise the next state is IDLE.
REQ-027 When AHB2WB_ERR_EN is undefined: wb_err_i SHALL be treated as wb_ack_i, HRESP SHALL be tied to 0, and ERR1/ERR2 SHALL not exist.

Verification
REQ-028 Zero-wait word write: HADDR=0x100, HWDATA=0xDEADBEEF, HSIZE=2 -> one cycle later cyc/stb=1, adr=0x100, sel=1111, dat=0xDEADBEEF, we=1; HREADYOUT low 1 cycle.
REQ-029 Byte read at 0x103 with 2 Wishbone wait states, wb_dat_i=0x11223344 -> sel=1000, HRDATA=0x11223344 with HREADYOUT=1, data phase 4 cycles.
REQ-030 Back-to-back: a write to 0x0 is followed, while in RESP, by a read of 0x4 accepted -> the second ACCESS starts in the next cycle with no IDLE gap.
REQ-031 wb_rty_i once, then ack -> stb drops for exactly one cycle, then is re-issued with unchanged adr/sel/dat; AHB sees one OKAY.
REQ-032 With AHB2WB_ERR_EN: wb_err_i on a write to 0x200 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1. Without the macro: the same stimulus gives an OKAY completion.
REQ-033 rst_i asserted mid-ACCESS -> cyc/stb=0 and HREADYOUT=1 in the same cycle; an ack arriving after rst_i is released causes no response.
